// File: rtl/branch_pred_unit.sv
// Branch prediction unit: 2-bit saturating-counter BHT indexed by microcode PC,
// branch condition resolver for JMP/JZ/JNE/JC, and saturating hit/miss statistics.
module branch_pred_unit #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pred_req,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [PC_W-1:0]   res_pc,
    input  logic [1:0]        res_type,
    input  logic              res_pred_taken,
    input  logic [DATA_W-1:0] W,
    input  logic              CY,
    output logic              checked,
    output logic              correct_pred,
    output logic              incorrect_pred,
    output logic              actual_taken,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_total,
    output logic [CNT_W-1:0]  stat_miss
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       r_bht [DEPTH];
    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_res_idx;
    logic             w_actual;
    logic             w_mispred;
    logic             w_bht_upd;
    logic [1:0]       w_cur_cnt;
    logic [1:0]       w_nxt_cnt;

    assign w_pred_idx = pred_pc[IDX_W-1:0];
    assign w_res_idx  = res_pc[IDX_W-1:0];
    assign w_cur_cnt  = r_bht[w_res_idx];

    always_comb begin
        w_actual = 1'b0;
        case (res_type)
            2'b00:   w_actual = 1'b1;
            2'b01:   w_actual = (W == {DATA_W{1'b0}});
            2'b10:   w_actual = ~W[DATA_W-1];
            default: w_actual = CY;
        endcase
    end

    assign w_mispred = (w_actual != res_pred_taken);
    // Unconditional jumps carry no direction information, so they never train.
    assign w_bht_upd = res_valid && (res_type != 2'b00);

    always_comb begin
        w_nxt_cnt = w_cur_cnt;
        if (w_actual && (w_cur_cnt != 2'b11))
            w_nxt_cnt = w_cur_cnt + 2'b01;
        else if (!w_actual && (w_cur_cnt != 2'b00))
            w_nxt_cnt = w_cur_cnt - 2'b01;
    end

    // Prediction reads the pre-update counter; a same-cycle update lands next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_bht[i] <= 2'b01;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            pred_valid <= pred_req;
            pred_taken <= pred_req ? r_bht[w_pred_idx][1] : 1'b0;
            if (w_bht_upd)
                r_bht[w_res_idx] <= w_nxt_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checked        <= 1'b0;
            correct_pred   <= 1'b0;
            incorrect_pred <= 1'b0;
            actual_taken   <= 1'b0;
        end else begin
            checked        <= res_valid;
            correct_pred   <= res_valid && !w_mispred;
            incorrect_pred <= res_valid && w_mispred;
            actual_taken   <= res_valid && w_actual;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total <= '0;
            stat_miss  <= '0;
        end else if (stat_clr) begin
            stat_total <= '0;
            stat_miss  <= '0;
        end else if (res_valid) begin
            if (stat_total != {CNT_W{1'b1}})
                stat_total <= stat_total + 1'b1;
            if (w_mispred && (stat_miss != {CNT_W{1'b1}}))
                stat_miss <= stat_miss + 1'b1;
        end
    end

endmodule

// File: doc/branch_pred_unit.md
Name: branch_pred_unit

Overview:
- Parametrised successor to the single-type JNE prediction checker in the MicroEV20 microsequencer.
- Holds a branch history table (BHT) of 2-bit saturating counters, indexed by microcode PC. The BHT supplies a registered taken/not-taken prediction.
- Resolves four branch condition types against W/CY, flags correct and incorrect predictions, and trains the table.
- Keeps saturating statistics counters for checked branches and mispredictions.

Parameters:
- DATA_W, 16: width of W operand; the sign bit is W[DATA_W-1].
- PC_W, 8: width of microcode PC.
- IDX_W, 4: BHT index width; DEPTH = 2**IDX_W; index = pc[IDX_W-1:0]. Requires IDX_W <= PC_W.
- CNT_W, 16: width of statistics counters.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pred_req  in  1  prediction request for pred_pc this cycle.
- pred_pc  in  PC_W  PC of the branch being fetched.
- pred_valid  out  1  registered; high for one cycle, one cycle after pred_req.
- pred_taken  out  1  registered prediction accompanying pred_valid.
- res_valid  in  1  resolve request; operands are valid this cycle.
- res_pc  in  PC_W  PC of the branch being resolved.
- res_type  in  2  condition: 00 JMP (always taken), 01 JZ (W==0), 10 JNE (taken when W[DATA_W-1]==0), 11 JC (CY==1).
- res_pred_taken  in  1  prediction originally used for this branch.
- W  in  DATA_W  ALU result being tested.
- CY  in  1  carry flag.
- checked  out  1  registered pulse, one cycle after res_valid.
- correct_pred  out  1  registered; valid with checked.
- incorrect_pred  out  1  registered; valid with checked; equals !correct_pred when checked=1.
- actual_taken  out  1  registered resolved outcome (redirect direction); valid with checked.
- stat_clr  in  1  synchronous clear of statistics.
- stat_total  out  CNT_W  count of resolved branches.
- stat_miss  out  CNT_W  count of mispredictions.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0; stat counters are 0.
  - Every BHT entry is 2'b01 (weakly not-taken).
- Prediction path:
  - On rising edge with pred_req=1: pred_valid<=1 and pred_taken<=bht[pred_pc[IDX_W-1:0]][1].
  - Otherwise pred_valid<=0 and pred_taken<=0.
  - Latency is one cycle. Back-to-back requests are allowed, one per cycle.
- Resolve path: on rising edge with res_valid=1:
  - actual = (type 00) 1; (01) W=={DATA_W{1'b0}}; (10) !W[DATA_W-1]; (11) CY.
  - checked<=1, actual_taken<=actual, correct_pred<=(actual==res_pred_taken), incorrect_pred<=(actual!=res_pred_taken).
  - BHT update for types 01/10/11 only:
    - actual=1: counter+1, saturating at 11.
    - actual=0: counter-1, saturating at 00.
  - Type 00 never modifies the BHT. Type 00 with res_pred_taken=0 still reports incorrect_pred.
- No res_valid: checked, correct_pred, incorrect_pred, actual_taken all <=0 (pulses, not held).
- Same-cycle pred_req and res_valid on the same index:
  - Prediction uses the pre-update counter (read-before-write).
  - The update is visible to requests in the following cycle.
- Statistics:
  - On res_valid, stat_total increments; stat_miss increments if mispredicted.
  - Both saturate at all-ones and never wrap.
  - stat_clr=1 zeroes both and overrides any increment in the same cycle.
- Aliasing: PCs sharing low IDX_W bits share an entry; this is by design, no tag check.
- Reset asserted mid-operation: immediate clear of all state including in-flight pulses. The first prediction after release uses 01, i.e. predicts not-taken.

Test Plan:
- Reset, then pred_req pc=0x05 -> next cycle pred_valid=1, pred_taken=0; following idle cycle pred_valid=0.
- Resolve pc=0x05, type 10, W=0x0010, res_pred_taken=0, three times -> each checked=1, incorrect_pred=1, actual_taken=1; counter 01->10->11->11. Subsequent pred_req pc=0x05 -> pred_taken=1. stat_total=3, stat_miss=3.
- Type 01 W=0x0000, type 11 CY=0, type 10 W=0x8000, all with res_pred_taken matching the outcome -> correct_pred=1, incorrect_pred=0, actual_taken=1/0/0 respectively.
- Type 00 res_pred_taken=0 on pc=0x07 -> incorrect_pred=1, actual_taken=1; later pred_req pc=0x07 -> pred_taken=0 (entry unchanged).
- Same-cycle pred_req and res_valid (type 11, CY=1) on pc=0x15, entry at 01 -> pred_taken=0 this time; next request -> pred_taken=1. Also checks aliasing of 0x15 with 0x05 when IDX_W=4.
- CNT_W=4: 16 resolves -> stat_total holds 4'hF. stat_clr asserted together with a mispredicted res_valid -> both stats read 0 next cycle. rst_n pulled low mid-burst -> all outputs 0 immediately.
